// File: rtl/instr_stream_encoder_if.sv
// instr_stream_encoder_if
//   Bundles the two streams that cross the encoder boundary:
//   - decoded field bundle stream (in_*), valid/ready handshake
//   - instruction memory write port (mem_*), strobe/ready handshake
//   Modports:
//   - slave  : the encoder (consumes bundles, drives memory writes)
//   - master : the producer / memory side (drives bundles, accepts writes)
//   Parameter AW is the instruction memory word-address width.

interface instr_stream_encoder_if #(
    parameter int AW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fmt;
    logic [6:0]    in_op;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          in_last;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;

    modport master (
        output in_valid, in_fmt, in_op, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_op, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
//   Packs decoded RV32 field bundles back into 32-bit instruction words,
//   buffers them in a DEPTH-entry FIFO and writes them sequentially into PE
//   instruction memory starting at start_addr. One load session runs from a
//   start pulse until the bundle flagged in_last has been taken and every
//   buffered word has been written.
//   Ports:
//   - clk, rst     : clock, synchronous active-high reset
//   - start        : 1-cycle pulse opening a session (only honoured when idle)
//   - start_addr   : first word address of the session
//   - bus (slave)  : bundle stream in, instruction memory write port out
//   - busy         : session in progress
//   - done         : 1-cycle pulse after the session's last word is written
//   - err          : sticky, a bundle was rejected during this session
//   - err_cnt      : number of rejected bundles this session, saturating

module instr_stream_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          start_addr,
    instr_stream_encoder_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             err_cnt
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          full;
    logic          empty;

    logic          in_ready_c;
    logic          mem_we_c;
    logic          accept;
    logic          reject;
    logic          push;
    logic          pop;
    logic [31:0]   enc_word;
    logic [AW-1:0] addr_q;

    // Bundle-to-word packing; immediates are byte offsets, so B and J drop
    // imm[0] and scatter the remaining bits into the RV32 field positions.
    always_comb begin
        enc_word = '0;
        case (bus.in_fmt)
            FMT_R: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, bus.in_rd, bus.in_op};
            FMT_I: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                               bus.in_rd, bus.in_op};
            FMT_S: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, bus.in_imm[4:0], bus.in_op};
            FMT_B: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                               bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                               bus.in_imm[11], bus.in_op};
            FMT_U: enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_op};
            FMT_J: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                               bus.in_imm[19:12], bus.in_rd, bus.in_op};
            default: enc_word = '0;
        endcase
    end

    // A rejected bundle still completes its handshake so the producer never
    // stalls on bad input; it is simply not pushed into the FIFO.
    always_comb begin
        full   = (count == (PW+1)'(DEPTH));
        empty  = (count == '0);
        accept = bus.in_valid && in_ready_c;
        reject = accept && ((bus.in_fmt > FMT_J) ||
                            (((bus.in_fmt == FMT_B) || (bus.in_fmt == FMT_J)) &&
                             bus.in_imm[0]));
        push   = accept && !reject;
        pop    = mem_we_c && bus.mem_ready;
        count_next = count + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FLUSH looks at the post-pop occupancy so done follows the final write
    // by exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && bus.in_last) state_next = FLUSH;
            FLUSH:   if (count_next == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = (state == RUN) && !full;
        mem_we_c   = !empty && ((state == RUN) || (state == FLUSH));
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    // Storage is deliberately not reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            addr_q  <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            if ((state == IDLE) && start) begin
                addr_q  <= start_addr;
                err     <= 1'b0;
                err_cnt <= '0;
            end else begin
                if (pop) begin
                    addr_q <= addr_q + AW'(1);
                end
                if (reject) begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
            end
        end
    end

    // The write data is forced to zero when no write is offered so the bus
    // never shows stale or uninitialised storage.
    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = mem_we_c ? fifo_mem[rd_ptr] : 32'd0;

endmodule
